// File: rtl/psram_arbiter.sv
// psram_arbiter
// Two-port request arbiter in front of the PSRAM QPI controller.
// Port A is the video fetch port and port B is the CPU port.
// One request at a time goes out on the controller strobe/busy/done handshake.
// The granted we/addr/din are held stable until the next grant.
// Read data comes back with a single-cycle acknowledge.
// Build option: define PSRAM_ARB_ROUND_ROBIN_EN to alternate grants on contention.
// When it is left undefined, port A has fixed priority over port B.
module psram_arbiter (
  input  logic        i_clk,
  input  logic        i_rst,
  // port A (video fetch)
  input  logic        i_a_req,
  input  logic        i_a_we,
  input  logic [23:0] i_a_addr,
  input  logic [15:0] i_a_din,
  output logic        o_a_ack,
  output logic [15:0] o_a_dout,
  // port B (CPU)
  input  logic        i_b_req,
  input  logic        i_b_we,
  input  logic [23:0] i_b_addr,
  input  logic [15:0] i_b_din,
  output logic        o_b_ack,
  output logic [15:0] o_b_dout,
  // controller side
  output logic        o_stb,
  output logic        o_we,
  output logic [23:0] o_addr,
  output logic [15:0] o_din,
  input  logic        i_busy,
  input  logic        i_done,
  input  logic [15:0] i_dout,
  // status
  output logic        o_ready,
  output logic        o_grant
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RECOVER
  } state_t;

  state_t state_reg;
  logic   any_req;
  logic   sel_b;
  logic   ctl_complete;

  assign any_req      = i_a_req | i_b_req;
  // done alone is not enough: it stays high from the previous transaction
  assign ctl_complete = ~i_busy & i_done;

  // Choose the port for the next grant; o_grant doubles as last-granted history
  always_comb begin
    sel_b = 1'b0;
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
    if (i_a_req && i_b_req) begin
      sel_b = ~o_grant;
    end else begin
      sel_b = i_b_req;
    end
`else
    sel_b = i_b_req & ~i_a_req;
`endif
  end

  // Transaction sequencer; every output is registered here
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg <= ST_INIT;
      o_a_ack   <= 1'b0;
      o_a_dout  <= '0;
      o_b_ack   <= 1'b0;
      o_b_dout  <= '0;
      o_stb     <= 1'b0;
      o_we      <= 1'b0;
      o_addr    <= '0;
      o_din     <= '0;
      o_ready   <= 1'b0;
      o_grant   <= 1'b0;
    end else begin
      // acks are single-cycle pulses
      o_a_ack <= 1'b0;
      o_b_ack <= 1'b0;
      case (state_reg)
        ST_INIT: begin
          if (ctl_complete) begin
            o_ready   <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (any_req) begin
            o_grant   <= sel_b;
            o_we      <= sel_b ? i_b_we   : i_a_we;
            o_addr    <= sel_b ? i_b_addr : i_a_addr;
            o_din     <= sel_b ? i_b_din  : i_a_din;
            o_stb     <= 1'b1;
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // busy proves the controller took the strobe
          if (i_busy) begin
            o_stb     <= 1'b0;
            state_reg <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (ctl_complete) begin
            if (o_grant) begin
              o_b_ack <= 1'b1;
              if (!o_we) begin
                o_b_dout <= i_dout;
              end
            end else begin
              o_a_ack <= 1'b1;
              if (!o_we) begin
                o_a_dout <= i_dout;
              end
            end
            state_reg <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          // lets the acked requestor drop req before IDLE looks again
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter.
// It includes a small behavioural controller and a reference model of grant order, latency and data.
module tb_psram_arbiter;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        a_req  = 1'b0;
  logic        a_we   = 1'b0;
  logic [23:0] a_addr = '0;
  logic [15:0] a_din  = '0;
  logic        b_req  = 1'b0;
  logic        b_we   = 1'b0;
  logic [23:0] b_addr = '0;
  logic [15:0] b_din  = '0;
  logic        a_ack, b_ack, stb, we, ready, grant;
  logic [15:0] a_dout, b_dout, din;
  logic [23:0] addr;
  logic        busy  = 1'b1;
  logic        done  = 1'b0;
  logic [15:0] cdout = '0;
  logic [77:0] outs;

  int checks = 0;
  int errors = 0;
  int a_ack_cnt = 0;
  int b_ack_cnt = 0;

  // controller model knobs and state
  bit          init_hold = 1'b1;
  int          ctl_delay = 0;
  int          ctl_len   = 2;
  int          ph  = 0;
  int          cnt = 0;
  logic        cwe   = 1'b0;
  logic [23:0] caddr = '0;
  logic [15:0] cdin  = '0;
  logic [23:0] cw_addr = '0;
  logic [15:0] cw_data = '0;

  // reference model state
  bit          model_last = 1'b0;
  logic [15:0] model_dout [2];

  always #5 clk = ~clk;

  assign outs = {a_ack, a_dout, b_ack, b_dout, stb, we, addr, din, ready, grant};

  psram_arbiter dut (
    .i_clk    (clk),
    .i_rst    (rst_n),
    .i_a_req  (a_req),
    .i_a_we   (a_we),
    .i_a_addr (a_addr),
    .i_a_din  (a_din),
    .o_a_ack  (a_ack),
    .o_a_dout (a_dout),
    .i_b_req  (b_req),
    .i_b_we   (b_we),
    .i_b_addr (b_addr),
    .i_b_din  (b_din),
    .o_b_ack  (b_ack),
    .o_b_dout (b_dout),
    .o_stb    (stb),
    .o_we     (we),
    .o_addr   (addr),
    .o_din    (din),
    .i_busy   (busy),
    .i_done   (done),
    .i_dout   (cdout),
    .o_ready  (ready),
    .o_grant  (grant)
  );

  // data the controller model returns for a read at a given address
  function automatic logic [15:0] ctl_data(input logic [23:0] a);
    if (a == 24'h123456) return 16'hBEEF;
    return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h3C3C;
  endfunction

  // which port the arbitration rule picks (1 = B)
  function automatic bit pick(input bit ra, input bit rb, input bit last);
`ifdef PSRAM_ARB_ROUND_ROBIN_EN
    if (ra && rb) return ~last;
`else
    if (ra && rb) return 1'b0;
`endif
    return rb;
  endfunction

  // controller: samples strobe, raises busy after ctl_delay extra cycles, holds it ctl_len cycles, then done
  always @(posedge clk) begin
    if (init_hold) begin
      busy <= 1'b1;
      done <= 1'b0;
      ph   <= 3;
    end else begin
      case (ph)
        0: if (stb) begin
             cwe   <= we;
             caddr <= addr;
             cdin  <= din;
             if (ctl_delay == 0) begin
               busy <= 1'b1;
               done <= 1'b0;
               cnt  <= ctl_len;
               ph   <= 2;
             end else begin
               cnt <= ctl_delay;
               ph  <= 1;
             end
           end
        1: if (cnt == 1) begin
             busy <= 1'b1;
             done <= 1'b0;
             cnt  <= ctl_len;
             ph   <= 2;
           end else begin
             cnt <= cnt - 1;
           end
        2: if (cnt == 1) begin
             busy <= 1'b0;
             done <= 1'b1;
             ph   <= 0;
             if (cwe) begin
               cw_addr <= caddr;
               cw_data <= cdin;
             end else begin
               cdout <= ctl_data(caddr);
             end
           end else begin
             cnt <= cnt - 1;
           end
        default: begin
          busy <= 1'b0;
          done <= 1'b1;
          ph   <= 0;
        end
      endcase
    end
  end

  // running ack totals
  always @(posedge clk) begin
    if (a_ack) a_ack_cnt <= a_ack_cnt + 1;
    if (b_ack) b_ack_cnt <= b_ack_cnt + 1;
  end

  // drive one request and observe it until its ack (bounded); returns observations only
  task automatic run_txn(input bit port, input bit wr, input logic [23:0] ad, input logic [15:0] dt,
                         input bit scramble, input bit drop_early,
                         output bit got, output int ack_cyc, output int stb_first,
                         output int stb_cnt, output int other_acks);
    got = 1'b0; ack_cyc = -1; stb_first = -1; stb_cnt = 0; other_acks = 0;
    repeat (2) @(negedge clk);
    if (port) begin
      b_we = wr; b_addr = ad; b_din = dt; b_req = 1'b1;
    end else begin
      a_we = wr; a_addr = ad; a_din = dt; a_req = 1'b1;
    end
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (stb) begin
        stb_cnt++;
        if (stb_first < 0) begin
          stb_first = c;
          if (scramble) begin
            if (port) begin b_we = ~wr; b_addr = $urandom; b_din = $urandom; end
            else      begin a_we = ~wr; a_addr = $urandom; a_din = $urandom; end
          end
          if (drop_early) begin
            if (port) b_req = 1'b0; else a_req = 1'b0;
          end
        end
      end
      if (port ? a_ack : b_ack) other_acks++;
      if (port ? b_ack : a_ack) begin
        got = 1'b1;
        ack_cyc = c;
        break;
      end
    end
    if (port) b_req = 1'b0; else a_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    init_hold = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== 78'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", outs);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({ready, stb} !== 2'b00) begin
      errors++; $display("FAIL reset_release_ready got %b want 00", {ready, stb});
    end
  endtask

  task automatic test_init();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if ({ready, stb} !== 2'b00) begin
        errors++; $display("FAIL init_hold cycle %0d ready/stb got %b want 00", i, {ready, stb});
      end
    end
    init_hold = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL init_early_ready got %b want 0", ready);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL init_ready got %b want 1", ready);
    end
    $display("txn init ready after done observed");
  endtask

  task automatic test_port_a_write();
    bit got; int ac, sf, sc, oth;
    ctl_delay = 0;
    ctl_len   = $urandom_range(1, 4);
    run_txn(1'b0, 1'b1, 24'h000010, 16'h5A5A, 1'b1, 1'b0, got, ac, sf, sc, oth);
    $display("txn A write addr=000010 din=5a5a len=%0d ack_cyc=%0d", ctl_len, ac);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL a_write_ack got %b want 1", got); end
    checks++;
    if (ac != 3 + ctl_len) begin errors++; $display("FAIL a_write_latency got %0d want %0d", ac, 3 + ctl_len); end
    checks++;
    if ({we, addr, din} !== {1'b1, 24'h000010, 16'h5A5A}) begin
      errors++; $display("FAIL a_write_hold got we=%b addr=%h din=%h want 1 000010 5a5a", we, addr, din);
    end
    checks++;
    if ({cw_addr, cw_data} !== {24'h000010, 16'h5A5A}) begin
      errors++; $display("FAIL a_write_ctl got %h/%h want 000010/5a5a", cw_addr, cw_data);
    end
    checks++;
    if (a_dout !== model_dout[0]) begin errors++; $display("FAIL a_write_dout got %h want %h", a_dout, model_dout[0]); end
    checks++;
    if (grant !== 1'b0 || oth != 0) begin errors++; $display("FAIL a_write_grant got %b/%0d want 0/0", grant, oth); end
    @(negedge clk);
    checks++;
    if (a_ack !== 1'b0) begin errors++; $display("FAIL a_ack_width got %b want 0", a_ack); end
    model_last = 1'b0;
  endtask

  task automatic test_port_b_read();
    bit got; int ac, sf, sc, oth;
    ctl_delay = 0;
    ctl_len   = $urandom_range(1, 4);
    run_txn(1'b1, 1'b0, 24'h123456, 16'h0000, 1'b0, 1'b0, got, ac, sf, sc, oth);
    $display("txn B read addr=123456 dout=%h ack_cyc=%0d", b_dout, ac);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL b_read_ack got %b want 1", got); end
    checks++;
    if (sf != 1 || sc != 2) begin errors++; $display("FAIL b_read_stb got first=%0d n=%0d want 1/2", sf, sc); end
    checks++;
    if ({we, addr} !== {1'b0, 24'h123456}) begin errors++; $display("FAIL b_read_addr got %b %h want 0 123456", we, addr); end
    checks++;
    if (b_dout !== 16'hBEEF) begin errors++; $display("FAIL b_read_dout got %h want beef", b_dout); end
    checks++;
    if (oth != 0 || grant !== 1'b1) begin errors++; $display("FAIL b_read_only got a_acks=%0d grant=%b want 0/1", oth, grant); end
    model_last    = 1'b1;
    model_dout[1] = 16'hBEEF;
  endtask

  task automatic test_simultaneous();
    logic [23:0] cur [2];
    bit exp_port, got;
    ctl_delay = 0;
    ctl_len   = 2;
    repeat (2) @(negedge clk);
    cur[0] = $urandom; cur[1] = $urandom;
    a_we = 1'b0; b_we = 1'b0;
    a_addr = cur[0]; b_addr = cur[1];
    a_req = 1'b1; b_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      exp_port = pick(1'b1, 1'b1, model_last);
      got = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (a_ack || b_ack) begin got = 1'b1; break; end
      end
      checks++;
      if (got !== 1'b1) begin
        errors++; $display("FAIL simul_timeout grant %0d got none want ack", g);
      end else begin
        $display("txn simul grant %0d port=%s dout=%h", g, b_ack ? "B" : "A", b_ack ? b_dout : a_dout);
        checks++;
        if ({a_ack, b_ack} !== (exp_port ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL simul_order grant %0d got a/b=%b want port %0d", g, {a_ack, b_ack}, exp_port);
        end
        checks++;
        if ((exp_port ? b_dout : a_dout) !== ctl_data(cur[exp_port])) begin
          errors++; $display("FAIL simul_dout grant %0d got %h want %h", g, exp_port ? b_dout : a_dout, ctl_data(cur[exp_port]));
        end
        model_dout[exp_port] = ctl_data(cur[exp_port]);
        model_last = exp_port;
        // re-request at once with a new address
        cur[exp_port] = $urandom;
        if (exp_port) b_addr = cur[1]; else a_addr = cur[0];
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    model_dout[0] = a_dout;
    model_dout[1] = b_dout;
  endtask

  task automatic test_stale_done();
    bit got; int ac, sf, sc, oth;
    logic [23:0] ad;
    ad = $urandom;
    ctl_delay = 3;
    ctl_len   = 2;
    run_txn(1'b0, 1'b0, ad, 16'h0000, 1'b0, 1'b1, got, ac, sf, sc, oth);
    $display("txn stale_done A read addr=%h ack_cyc=%0d stb_cycles=%0d", ad, ac, sc);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL stale_ack got %b want 1", got); end
    checks++;
    if (ac != 8) begin errors++; $display("FAIL stale_latency got %0d want 8", ac); end
    checks++;
    if (sc != 5) begin errors++; $display("FAIL stale_stb_cycles got %0d want 5", sc); end
    checks++;
    if (a_dout !== ctl_data(ad)) begin errors++; $display("FAIL stale_dout got %h want %h", a_dout, ctl_data(ad)); end
    model_dout[0] = ctl_data(ad);
    model_last    = 1'b0;
    ctl_delay     = 0;
  endtask

  task automatic test_random();
    bit got, port, wr; int ac, sf, sc, oth;
    logic [23:0] ad; logic [15:0] dt, obs;
    for (int t = 0; t < 12; t++) begin
      port = $urandom_range(0, 1);
      wr   = $urandom_range(0, 1);
      ad   = $urandom;
      dt   = $urandom;
      ctl_delay = $urandom_range(0, 2);
      ctl_len   = $urandom_range(1, 5);
      run_txn(port, wr, ad, dt, 1'b0, 1'b0, got, ac, sf, sc, oth);
      obs = port ? b_dout : a_dout;
      $display("txn rnd %0d port=%s we=%0d addr=%h din=%h dout=%h ack_cyc=%0d", t, port ? "B" : "A", wr, ad, dt, obs, ac);
      checks++;
      if (got !== 1'b1) begin errors++; $display("FAIL rnd_ack %0d got %b want 1", t, got); end
      checks++;
      if (ac != 3 + ctl_delay + ctl_len) begin
        errors++; $display("FAIL rnd_latency %0d got %0d want %0d", t, ac, 3 + ctl_delay + ctl_len);
      end
      checks++;
      if (sf != 1 || sc != 2 + ctl_delay) begin
        errors++; $display("FAIL rnd_stb %0d got first=%0d n=%0d want 1/%0d", t, sf, sc, 2 + ctl_delay);
      end
      checks++;
      if ({grant, we, addr} !== {pick(!port, port, model_last), wr, ad} || oth != 0) begin
        errors++; $display("FAIL rnd_grant %0d got g=%b we=%b addr=%h oth=%0d want %b %b %h 0", t, grant, we, addr, oth, port, wr, ad);
      end
      if (wr) begin
        checks++;
        if ({cw_addr, cw_data} !== {ad, dt} || obs !== model_dout[port]) begin
          errors++; $display("FAIL rnd_write %0d got ctl=%h/%h dout=%h want %h/%h %h", t, cw_addr, cw_data, obs, ad, dt, model_dout[port]);
        end
      end else begin
        checks++;
        if (obs !== ctl_data(ad)) begin
          errors++; $display("FAIL rnd_read %0d got %h want %h", t, obs, ctl_data(ad));
        end
        model_dout[port] = ctl_data(ad);
      end
      model_last = port;
    end
  endtask

  task automatic test_reset_mid();
    int pre_a, pre_b;
    bit got; int ac, sf, sc, oth;
    logic [23:0] ad;
    ctl_delay = 0;
    ctl_len   = 12;
    repeat (3) @(negedge clk);
    pre_a = a_ack_cnt;
    pre_b = b_ack_cnt;
    a_we = 1'b0; a_addr = $urandom; a_req = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({stb, busy} !== 2'b01) begin errors++; $display("FAIL mid_wait_state got stb/busy=%b want 01", {stb, busy}); end
    #2;
    rst_n = 1'b0;
    init_hold = 1'b1;
    #1;
    checks++;
    if (outs !== 78'd0) begin errors++; $display("FAIL mid_reset_outputs got %h want 0", outs); end
    $display("txn reset during wait_done");
    @(negedge clk);
    a_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({ready, stb} !== 2'b00) begin errors++; $display("FAIL mid_reinit cycle %0d got %b want 00", i, {ready, stb}); end
    end
    checks++;
    if (a_ack_cnt != pre_a || b_ack_cnt != pre_b) begin
      errors++; $display("FAIL mid_no_ack got %0d/%0d want %0d/%0d", a_ack_cnt, b_ack_cnt, pre_a, pre_b);
    end
    init_hold = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", ready); end
    model_last = 1'b0;
    model_dout[0] = 16'h0000;
    model_dout[1] = 16'h0000;
    ctl_len = 3;
    ad = $urandom;
    run_txn(1'b1, 1'b0, ad, 16'h0000, 1'b0, 1'b0, got, ac, sf, sc, oth);
    $display("txn post_reset B read addr=%h dout=%h ack_cyc=%0d", ad, b_dout, ac);
    checks++;
    if (got !== 1'b1 || b_dout !== ctl_data(ad) || ac != 6) begin
      errors++; $display("FAIL post_reset_read got ack=%b dout=%h cyc=%0d want 1 %h 6", got, b_dout, ac, ctl_data(ad));
    end
  endtask

  initial begin
    model_dout[0] = 16'h0000;
    model_dout[1] = 16'h0000;
    test_reset();
    test_init();
    test_port_a_write();
    test_port_b_read();
    test_simultaneous();
    test_stale_done();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
